// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-pointer sequencer with a hardware call/return stack.
// Holds pc, advances it by STEP, a signed offset or an absolute target, and
// tracks return addresses in a LIFO indexed by depth. A sticky fault freezes
// all sequencing state until clear_fault or reset.
module pc_sequencer #(
    parameter int unsigned           WORD_WIDTH  = 16,
    parameter int unsigned           STACK_DEPTH = 8,
    parameter logic [WORD_WIDTH-1:0] RESET_ADDR  = '0,
    parameter logic [WORD_WIDTH-1:0] STEP        = WORD_WIDTH'(1)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               en,
    input  logic [2:0]                         mode,
    input  logic [WORD_WIDTH-1:0]              adj,
    input  logic [WORD_WIDTH-1:0]              target,
    input  logic                               clear_fault,
    output logic [WORD_WIDTH-1:0]              pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_empty,
    output logic                               stack_full,
    output logic                               fault,
    output logic [1:0]                         fault_code
);

    localparam int unsigned DEPTH_WIDTH = $clog2(STACK_DEPTH + 1);
    localparam int unsigned INDEX_WIDTH = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] MODE_NEXT     = 3'd0;
    localparam logic [2:0] MODE_REL      = 3'd1;
    localparam logic [2:0] MODE_ABS      = 3'd2;
    localparam logic [2:0] MODE_CALL_REL = 3'd3;
    localparam logic [2:0] MODE_CALL_ABS = 3'd4;
    localparam logic [2:0] MODE_RET      = 3'd5;

    localparam logic [1:0] FAULT_NONE      = 2'd0;
    localparam logic [1:0] FAULT_OVERFLOW  = 2'd1;
    localparam logic [1:0] FAULT_UNDERFLOW = 2'd2;

    logic [WORD_WIDTH-1:0]  stack_mem [STACK_DEPTH];
    logic [WORD_WIDTH-1:0]  pc_next;
    logic [DEPTH_WIDTH-1:0] depth_next;
    logic                   fault_next;
    logic [1:0]             fault_code_next;
    logic                   push_en;
    logic [WORD_WIDTH-1:0]  ret_addr;
    logic [INDEX_WIDTH-1:0] push_idx;
    logic [INDEX_WIDTH-1:0] pop_idx;

    // Push goes to entry[depth], pop reads entry[depth-1]; the return address is pc+STEP.
    assign ret_addr = pc + STEP;
    assign push_idx = INDEX_WIDTH'(depth);
    assign pop_idx  = INDEX_WIDTH'(depth - DEPTH_WIDTH'(1));

    // Sequencing state: pc, stack depth and the sticky fault, reset asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc         <= RESET_ADDR;
            depth      <= '0;
            fault      <= 1'b0;
            fault_code <= FAULT_NONE;
        end else begin
            pc         <= pc_next;
            depth      <= depth_next;
            fault      <= fault_next;
            fault_code <= fault_code_next;
        end
    end

    // Return-address storage; contents are meaningless above depth, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[push_idx] <= ret_addr;
        end
    end

    // Next-state decode: clear_fault wins, a pending fault freezes everything, then en/mode.
    always_comb begin
        pc_next         = pc;
        depth_next      = depth;
        fault_next      = fault;
        fault_code_next = fault_code;
        push_en         = 1'b0;
        if (clear_fault) begin
            fault_next      = 1'b0;
            fault_code_next = FAULT_NONE;
        end else if (!fault && en) begin
            case (mode)
                MODE_NEXT: pc_next = pc + STEP;
                MODE_REL:  pc_next = pc + adj;
                MODE_ABS:  pc_next = target;
                MODE_CALL_REL, MODE_CALL_ABS: begin
                    if (stack_full) begin
                        fault_next      = 1'b1;
                        fault_code_next = FAULT_OVERFLOW;
                    end else begin
                        push_en    = 1'b1;
                        depth_next = depth + DEPTH_WIDTH'(1);
                        pc_next    = (mode == MODE_CALL_REL) ? (pc + adj) : target;
                    end
                end
                MODE_RET: begin
                    if (stack_empty) begin
                        fault_next      = 1'b1;
                        fault_code_next = FAULT_UNDERFLOW;
                    end else begin
                        pc_next    = stack_mem[pop_idx];
                        depth_next = depth - DEPTH_WIDTH'(1);
                    end
                end
                default: pc_next = pc;
            endcase
        end
    end

    // Stack status flags decoded straight from the registered depth.
    always_comb begin
        stack_empty = (depth == '0);
        stack_full  = (depth == DEPTH_WIDTH'(STACK_DEPTH));
    end

endmodule
